instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writes program words into the instruction memory that the fetch stage reads, taking a byte stream from the host link and packing it into 32-bit instructions. It holds the core in reset while loading and releases it only after a complete, valid program is in memory. It sits between the host byte interface and the instruction memory write port, in parallel with the fetch stage's read port.

## Interface
- ADDR_W, 10: instruction memory address width; capacity 2**ADDR_W words.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; begins a load session.
- BYTE_IN  in  8  host byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- WE  out  1  instruction memory write enable (one-cycle pulse per word).
- WADDR  out  ADDR_W  write word address.
- WDATA  out  32  write word.
- CORE_RST  out  1  holds the pipeline (PC register included) in reset.
- BUSY  out  1  session in progress.
- DONE  out  1  one-cycle pulse on successful completion.
- ERROR  out  1  sticky; set on length overflow or checksum failure, cleared by START or RST.

## Operation
- Byte transfer occurs on a cycle with BYTE_VALID && BYTE_READY. BYTE_VALID must not depend combinationally on BYTE_READY.
- Frame: LEN_LO, LEN_HI (N = 16-bit word count, little-endian), then 4·N payload bytes, each word little-endian (first byte = WDATA[7:0]).
- States: IDLE -> LEN_LO -> LEN_HI -> DATA -> (CHECK) -> FINISH -> IDLE; any state -> FAIL on error; FAIL -> IDLE on the next cycle.
- IDLE: BYTE_READY=0. START moves to LEN_LO, clears ERROR and the address counter, and asserts CORE_RST and BUSY.
- LEN_HI accepted: if N > 2**ADDR_W, go to FAIL; otherwise go to DATA, or to CHECK/FINISH when N=0.
- DATA: a byte counter (0..3) packs bytes. On the 4th byte, WE=1 with WADDR=current address and WDATA=the packed word on the following cycle, then the address increments. After word N is written, go to CHECK/FINISH.
- FINISH: DONE=1 for one cycle and CORE_RST deasserts in the same cycle.
- FAIL: ERROR=1, CORE_RST stays 1, DONE is not pulsed. Words already written remain in memory.
- START while BUSY is ignored. Bytes presented in IDLE are not consumed.
- Address never wraps, because the N bound is checked up front. The address counter is ADDR_W+1 bits internally.

## Timing
- Reset values: BYTE_READY=0, WE=0, WADDR=0, WDATA=0, CORE_RST=1, BUSY=0, DONE=0, ERROR=0. The core stays held after power-up until the first successful load.
- START to BYTE_READY=1: 1 cycle.
- BYTE_READY is 1 in every receiving state, so one byte can be accepted per cycle at full rate.
- 4th byte accepted at cycle t: WE at t+1.
- Last write at cycle t: DONE and CORE_RST=0 at t+1 (no checksum) or after the checksum byte is accepted.
- RST mid-session: the next cycle is IDLE with CORE_RST=1 and BUSY=0. Any pending WE is cancelled.

## Configuration
- LOADER_CHECKSUM_EN defined: the frame carries one trailing byte after the payload, which must equal the XOR of all payload bytes. It is received in state CHECK. A match goes to FINISH; a mismatch goes to FAIL.
- LOADER_CHECKSUM_EN undefined: there is no CHECK state and no trailing byte. DATA and N=0 go straight to FINISH.

## Structure
- Package asip_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, FINISH, FAIL);
  - INSTR_W=32;
  - BYTES_PER_WORD=4;
  - LEN_W=16.
- Sub-module word_packer: shift/byte-lane register plus 2-bit lane counter. It takes a byte strobe and emits the word with a word-valid strobe. It is cleared on START/RST.

## Test plan
- Clean load: N=2, bytes 02 00 78 56 34 12 EF BE AD DE -> WE at addr 0 with 0x12345678, WE at addr 1 with 0xDEADBEEF, then DONE and CORE_RST=0; ERROR=0.
- Throttled source: same frame with BYTE_VALID low every other cycle -> identical writes, no dropped or duplicated bytes.
- Overflow: ADDR_W=4, N=17 -> FAIL, ERROR=1, no WE, CORE_RST stays 1; a following START clears ERROR.
- Empty program: N=0 -> no WE, DONE 1 cycle after LEN_HI (or after the checksum byte when checksum is enabled).
- Reset mid-load: RST after the 6th byte of the N=2 frame -> IDLE next cycle, CORE_RST=1, BUSY=0, no further WE; START while BUSY in another run is ignored.
- With LOADER_CHECKSUM_EN: correct XOR 0x00 -> DONE; wrong byte 0x01 -> ERROR=1, CORE_RST=1.

Source files
------------

// File: rtl/asip_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asip_loader_pkg
//  Description : Shared types and constants for the instruction loader:
//                loader state encoding, instruction word width, bytes per
//                word and the width of the frame length field.
//  Revision    : 1.0 - initial release
// ============================================================================
package asip_loader_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    FINISH = 3'd5,
    FAIL   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : Packs a little-endian byte stream into 32-bit words. The
//                first byte of a word lands in bits [7:0]. When the last
//                byte of a word is strobed, the full word is presented on
//                the following cycle together with a one-cycle word_valid.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr           - synchronous clear (start of a session)
//                byte_stb      - byte_in is consumed this cycle
//                byte_in       - payload byte
//                lane          - index of the next byte within the word
//                word_valid    - one-cycle strobe, word holds a new value
//                word          - packed word (held until the next word)
//  Revision    : 1.0 - initial release
// ============================================================================
module word_packer
  import asip_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_stb,
  input  logic [7:0]         byte_in,
  output logic [1:0]         lane,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  // Lower three bytes collected so far; the fourth byte is merged in
  // directly when the word is emitted.
  logic [INSTR_W-9:0] low;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane       <= 2'd0;
      low        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_stb) begin
        if (lane == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {byte_in, low};
          word_valid <= 1'b1;
          lane       <= 2'd0;
        end else begin
          low[{lane, 3'b000} +: 8] <= byte_in;
          lane                     <= lane + 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_loader
//  Description : Receives a program frame over a byte link (16-bit LE word
//                count, then 4*N LE payload bytes) and writes it into the
//                instruction memory. The core is held in reset from START
//                until a complete, valid program has been written.
//  Options     : LOADER_CHECKSUM_EN - frame carries one trailing byte equal
//                to the XOR of all payload bytes, checked in state CHECK.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                START             - one-cycle pulse, begins a session
//                BYTE_IN/VALID     - host byte stream
//                BYTE_READY        - a byte is accepted this cycle
//                WE/WADDR/WDATA    - instruction memory write port
//                CORE_RST          - holds the pipeline in reset
//                BUSY              - session in progress
//                DONE              - one-cycle pulse on success
//                ERROR             - sticky failure flag
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
  import asip_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [7:0]         BYTE_IN,
  input  logic               BYTE_VALID,
  output logic               BYTE_READY,
  output logic               WE,
  output logic [ADDR_W-1:0]  WADDR,
  output logic [INSTR_W-1:0] WDATA,
  output logic               CORE_RST,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERROR
);

  localparam int MAX_WORDS = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
`else
  localparam state_t AFTER_DATA = FINISH;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         len_lo;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_rx;
  logic [ADDR_W:0]    addr;      // words written; one extra bit for N = capacity
  logic [ADDR_W:0]    rx_words;  // words fully received
  logic               xfer;
  logic               session_start;
  logic               len_over;
  logic               last_byte;
  logic               last_write;
  logic [1:0]         pk_lane;
  logic               pk_valid;
  logic [INSTR_W-1:0] pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign xfer          = BYTE_VALID && BYTE_READY;
  assign session_start = (state == IDLE) && START;
  assign len_rx        = {BYTE_IN, len_lo};
  assign len_over      = 32'(len_rx) > 32'(MAX_WORDS);
  // Final payload byte: stop accepting until the FSM leaves DATA.
  assign last_byte     = (state == DATA) && xfer &&
                         (pk_lane == 2'(BYTES_PER_WORD - 1)) &&
                         (32'(rx_words) + 32'd1 == 32'(len));
  assign last_write    = pk_valid && (32'(addr) + 32'd1 == 32'(len));

  word_packer u_packer (
    .clk        (CLK),
    .rst        (RST),
    .clr        (session_start),
    .byte_stb   (xfer && (state == DATA)),
    .byte_in    (BYTE_IN),
    .lane       (pk_lane),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // The packer's outputs are already registered and reset with RST, which
  // also cancels any write that was pending when RST arrived.
  assign WE    = pk_valid;
  assign WADDR = addr[ADDR_W-1:0];
  assign WDATA = pk_word;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (START) state_nxt = LEN_LO;
      LEN_LO: if (xfer)  state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_over)
            state_nxt = FAIL;
          else if (len_rx == '0)
            state_nxt = AFTER_DATA;
          else
            state_nxt = DATA;
        end
      end
      DATA:   if (last_write) state_nxt = AFTER_DATA;
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) state_nxt = (BYTE_IN == csum) ? FINISH : FAIL;
`else
        state_nxt = FAIL;
`endif
      end
      FINISH: state_nxt = IDLE;
      FAIL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      BYTE_READY <= 1'b0;
      CORE_RST   <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      addr       <= '0;
      rx_words   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      DONE  <= (state_nxt == FINISH);

      case (state_nxt)
        LEN_LO, LEN_HI, CHECK: BYTE_READY <= 1'b1;
        DATA:    BYTE_READY <= (state != DATA) || (BYTE_READY && !last_byte);
        default: BYTE_READY <= 1'b0;
      endcase

      if (session_start) begin
        ERROR    <= 1'b0;
        CORE_RST <= 1'b1;
        addr     <= '0;
        rx_words <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      if (state_nxt == FAIL)   ERROR    <= 1'b1;
      if (state_nxt == FINISH) CORE_RST <= 1'b0;

      if ((state == LEN_LO) && xfer) len_lo <= BYTE_IN;
      if ((state == LEN_HI) && xfer) len    <= len_rx;

      if (pk_valid) addr <= addr + (ADDR_W+1)'(1);

      if ((state == DATA) && xfer) begin
        if (pk_lane == 2'(BYTES_PER_WORD - 1))
          rx_words <= rx_words + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ BYTE_IN;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_loader
//  Description : Self-checking bench for instruction_loader (ADDR_W = 4).
//                Frames are parsed by a reference model into an expected
//                write list and outcome; a monitor matches memory writes
//                and DONE pulses against it.
//  Options     : LOADER_CHECKSUM_EN - bench appends/verifies checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              error;

  instruction_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .BYTE_IN    (byte_in),
    .BYTE_VALID (byte_valid),
    .BYTE_READY (byte_ready),
    .WE         (we),
    .WADDR      (waddr),
    .WDATA      (wdata),
    .CORE_RST   (core_rst),
    .BUSY       (busy),
    .DONE       (done),
    .ERROR      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];

  // Parse the first `limit` bytes of the frame: list the words that must be
  // written and whether the session must end in success.
  task automatic model(input int limit, output bit ok);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    ok = 1'b0;
    if (limit < 2 || frame.size() < 2) return;
    n = int'(frame[0]) + 256 * int'(frame[1]);
    if (n > CAP) return;
    for (int w = 0; w < n; w++) begin
      if (4 * w + 6 <= limit) begin
        exp_addr.push_back(ADDR_W'(w));
        exp_data.push_back({frame[5+4*w], frame[4+4*w], frame[3+4*w], frame[2+4*w]});
      end
    end
    if (limit < 2 + 4 * n + CSUM) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x = x ^ frame[2+i];
    ok = (CSUM == 0) || (frame[2+4*n] == x);
  endtask

  task automatic build(input int n, input int nwords, input bit bad, input bit fixed);
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  x;
    nn = 16'(n);
    x  = 8'h00;
    frame.delete();
    frame.push_back(nn[7:0]);
    frame.push_back(nn[15:8]);
    for (int i = 0; i < nwords; i++) begin
      if (fixed) w = (i == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF;
      else       w = $urandom;
      for (int b = 0; b < 4; b++) begin
        frame.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    if (CSUM != 0) frame.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // ---------------- monitor ----------------
  int done_cnt;
  int done_cyc;
  int last_we_cyc;
  int last_acc_cyc;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (we) begin
      last_we_cyc = cyc;
      if (exp_addr.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        check("waddr", 32'(waddr), 32'(exp_addr.pop_front()));
        check("wdata", wdata, exp_data.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // vmode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random
  task automatic drive(input int vmode, input int max_acc, input int start_at, output int nacc);
    int budget;
    bit v, acc, tog, at_pos;
    budget = 3000;
    tog    = 1'b0;
    at_pos = 1'b0;
    nacc   = 0;
    while (nacc < frame.size() && nacc < max_acc) begin
      @(negedge clk);
      at_pos = 1'b0;
      if (!busy) break;
      if (budget == 0) begin
        check("drive_timeout", 0, 1);
        break;
      end
      budget--;
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_in    = frame[nacc];
      byte_valid = v;
      start      = (nacc == start_at);
      acc        = v && byte_ready;
      if (acc) last_acc_cyc = cyc;
      @(posedge clk);
      at_pos = 1'b1;
      if (acc) nacc++;
    end
    if (at_pos) @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic session(input string nm, input int n, input int nwords, input bit bad,
                         input bit fixed, input int vmode, input int start_at);
    bit ok;
    int nacc;
    build(n, nwords, bad, fixed);
    model(frame.size(), ok);
    done_cnt    = 0;
    done_cyc    = -100;
    last_we_cyc = -100;
    pulse_start();
    check("ready_after_start", 32'(byte_ready), 1);
    check("busy_after_start", 32'(busy), 1);
    check("error_cleared", 32'(error), 0);
    drive(vmode, 1 << 30, start_at, nacc);
    wait_idle();
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 32'(ok));
    check("error_flag", 32'(error), 32'(!ok));
    check("core_rst", 32'(core_rst), 32'(!ok));
    check("writes_left", exp_addr.size(), 0);
    if (ok) begin
      check("done_gap", done_cyc - last_acc_cyc, (n > 0 && CSUM == 0) ? 2 : 1);
      if (n > 0 && CSUM == 0) check("we_to_done", done_cyc - last_we_cyc, 1);
    end
    $display("session %s: n=%0d ok=%0b accepted=%0d", nm, n, ok, nacc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nacc;
    int n;
    bit ok;
    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    done_cnt   = 0;
    done_cyc   = -100;
    last_we_cyc = -100;
    last_acc_cyc = -100;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_we", 32'(we), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", wdata, 0);
    check("rst_core_rst", 32'(core_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    rst = 1'b0;

    // Bytes offered while idle are not consumed.
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(byte_ready), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_core_rst", 32'(core_rst), 1);
    byte_valid = 1'b0;

    session("clean", 2, 2, 1'b0, 1'b1, 0, -1);
    session("throttled", 2, 2, 1'b0, 1'b1, 1, -1);
    session("overflow", CAP + 1, CAP + 1, 1'b0, 1'b0, 0, -1);
    session("empty", 0, 0, 1'b0, 1'b0, 0, -1);
    if (CSUM != 0) begin
      session("empty_badsum", 0, 0, 1'b1, 1'b0, 0, -1);
      session("clean_badsum", 2, 2, 1'b1, 1'b1, 2, -1);
    end
    session("full", CAP, CAP, 1'b0, 1'b0, 2, 4);
    session("huge_len", 65535, 0, 1'b0, 1'b0, 0, -1);

    // Reset in the cycle after the 6th byte: first word still lands,
    // nothing after it.
    build(2, 2, 1'b0, 1'b1);
    model(6, ok);
    done_cnt = 0;
    pulse_start();
    drive(0, 6, -1, nacc);
    check("rst_mid_accepted", nacc, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_core_rst", 32'(core_rst), 1);
    check("rst_mid_ready", 32'(byte_ready), 0);
    check("rst_mid_we", 32'(we), 0);
    repeat (8) @(negedge clk);
    check("rst_mid_writes_left", exp_addr.size(), 0);
    check("rst_mid_done", done_cnt, 0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, CAP);
      session("random", n, n, (CSUM != 0) && ($urandom_range(0, 3) == 0), 1'b0,
              $urandom_range(0, 2), (n >= 2) ? 4 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
